regfile_hilo: RTL and testbench
===============================

Name: regfile_hilo

Overview:
- Architectural state sink at the far end of the writeback-to-register-file bus.
- Unpacks the WB stage's packed write bus and commits GPR and HI/LO updates on the clock edge.
- Serves the ID stage with two combinational GPR read ports plus the current HI/LO values.
- Contents: 32x32 GPR array with $0 hard-wired to zero, and HI/LO register pair.

Parameters:
- None. All widths come from `lib/defines.vh`:
  - `WB_TO_RF_WD` = 104
  - data width 32
  - register address width 5

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- wb_to_rf_bus  in  WB_TO_RF_WD  packed write bus, MSB to LSB: {w_hi_we[1], w_hi_i[32], w_lo_we[1], w_lo_i[32], rf_we[1], rf_waddr[5], rf_wdata[32]}
- raddr1  in  5  GPR read address, port 1 (rs)
- raddr2  in  5  GPR read address, port 2 (rt)
- rdata1  out  32  GPR read data, port 1
- rdata2  out  32  GPR read data, port 2
- hi_o  out  32  current HI value
- lo_o  out  32  current LO value

Behaviour:
- Reset:
  - At a rising clk edge with rst=1, GPR[1..31], HI and LO are all cleared to 0.
  - rst overrides any simultaneous write on the bus.
  - While rst=1, rdata1, rdata2, hi_o and lo_o are forced to 0 (bypass is suppressed).
- GPR write:
  - On a rising edge with rst=0, rf_we=1 and rf_waddr!=0: GPR[rf_waddr] <= rf_wdata.
  - rf_waddr=0 is discarded; GPR[0] is never stored and always reads 0.
- HI/LO write:
  - On a rising edge with rst=0, w_hi_we=1: HI <= w_hi_i.
  - On a rising edge with rst=0, w_lo_we=1: LO <= w_lo_i.
  - The two enables are independent; both may fire in the same cycle as a GPR write.
- Reads: fully combinational, zero latency.
  - rdata1 = 0 if raddr1=0, else GPR[raddr1]. Port 2 is identical using raddr2.
  - hi_o = HI; lo_o = LO.
- Write latency: a value written at edge N is visible from the array after edge N, i.e. in cycle N+1.
- Simultaneous events:
  - raddr1 = raddr2 = rf_waddr: both ports return the same value (stored value, or bypass value when the optional feature is enabled).
  - All-zero bus (WB bubble after a stall): no state change.
- No handshake and no backpressure: every cycle's bus content is consumed unconditionally. Stall and bubble handling are done upstream in WB.

Optional Feature:
- Macro: `REGFILE_BYPASS_EN`
- Defined (same-cycle write-through):
  - If rf_we=1, rf_waddr!=0 and rf_waddr=raddrN, then rdataN = rf_wdata in the same cycle.
  - If w_hi_we=1, then hi_o = w_hi_i; if w_lo_we=1, then lo_o = w_lo_i.
  - Bypass is gated off while rst=1.
- Undefined:
  - Reads return the stored value only.
  - The same-cycle WB hazard is resolved by the existing wb_to_id forwarding in ID.

Decomposition:
- `lib/defines.vh` holds:
  - `WB_TO_RF_WD`
  - field bit offsets: `RF_WDATA_LSB`=0, `RF_WADDR_LSB`=32, `RF_WE_BIT`=37, `LO_I_LSB`=38, `LO_WE_BIT`=70, `HI_I_LSB`=71, `HI_WE_BIT`=103
  - `ZeroWord`
- Sub-module `hilo_reg`: HI/LO storage plus its bypass, instantiated once. The GPR array stays in the top.

Test Plan:
- Reset then read: rst=1 for 2 cycles, raddr1=5, raddr2=31 -> rdata1=0, rdata2=0, hi_o=0, lo_o=0; the same values hold after rst deasserts.
- Basic write/read: bus rf_we=1, waddr=8, wdata=0xDEADBEEF for one cycle, then bus=0, raddr1=8 -> rdata1=0xDEADBEEF from the next cycle onward.
- $0 protection: rf_we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 with raddr1=0 stays 0 in all cycles.
- HI/LO independent writes:
  - w_hi_we=1, w_hi_i=0x12345678, w_lo_we=0 -> hi_o=0x12345678, lo_o unchanged (0).
  - Next, w_lo_we=1, w_lo_i=0x9ABCDEF0 -> lo_o=0x9ABCDEF0, hi_o still 0x12345678.
- Same-cycle hazard: GPR[3]=0x11 preloaded; in one cycle rf_we=1, waddr=3, wdata=0x22, raddr1=raddr2=3:
  - with `REGFILE_BYPASS_EN` -> both ports read 0x22 that cycle;
  - without it -> both read 0x11 that cycle and 0x22 the next.
- Reset priority: rst=1 together with rf_we=1, waddr=4, wdata=0xAA, w_hi_we=1, w_hi_i=0xBB -> after the edge, GPR[4]=0 and hi_o=0.

Source files
------------

// File: rtl/regfile_hilo_pkg.sv
// regfile_hilo_pkg: shared widths, write-bus field layout and the packed
// view of the writeback-to-register-file bus used by regfile_hilo.
//
// Bus layout, MSB to LSB:
//   {w_hi_we[1], w_hi_i[32], w_lo_we[1], w_lo_i[32],
//    rf_we[1], rf_waddr[5], rf_wdata[32]}
package regfile_hilo_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int NUM_REGS    = 32;
  localparam int WB_TO_RF_WD = 104;

  // Field bit offsets inside wb_to_rf_bus.
  localparam int RF_WDATA_LSB = 0;
  localparam int RF_WADDR_LSB = 32;
  localparam int RF_WE_BIT    = 37;
  localparam int LO_I_LSB     = 38;
  localparam int LO_WE_BIT    = 70;
  localparam int HI_I_LSB     = 71;
  localparam int HI_WE_BIT    = 103;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // Packed view of the bus; member order matches the offsets above.
  typedef struct packed {
    logic              hi_we;
    logic [DATA_W-1:0] hi_i;
    logic              lo_we;
    logic [DATA_W-1:0] lo_i;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
  } wb_to_rf_t;

endpackage

// File: rtl/regfile_hilo_hilo_reg.sv
// hilo_reg: HI/LO register pair with optional same-cycle write-through.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   hi_we, hi_i   HI write enable / data, committed on the rising edge
//   lo_we, lo_i   LO write enable / data, committed on the rising edge
//   hi_o, lo_o    current HI / LO; forced to zero while rst=1
//
// Build option: REGFILE_BYPASS_EN makes a pending write visible on
// hi_o / lo_o in the same cycle it is presented.
module hilo_reg
  import regfile_hilo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_i,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Reset wins over any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else begin
      if (hi_we) hi_q <= hi_i;
      if (lo_we) lo_q <= lo_i;
    end
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
`ifdef REGFILE_BYPASS_EN
    if (hi_we) hi_o = hi_i;
    if (lo_we) lo_o = lo_i;
`endif
    // Outputs read as zero during reset, which also kills any bypass.
    if (rst) begin
      hi_o = ZERO_WORD;
      lo_o = ZERO_WORD;
    end
  end

endmodule

// File: rtl/regfile_hilo.sv
// regfile_hilo: architectural register file at the end of the WB bus.
// Unpacks the packed writeback bus, commits GPR and HI/LO updates on the
// rising edge and serves two combinational GPR read ports plus HI/LO.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (clears GPRs, HI, LO)
//   wb_to_rf_bus   packed write bus, layout in regfile_hilo_pkg
//   raddr1/raddr2  GPR read addresses (rs / rt)
//   rdata1/rdata2  GPR read data, zero-latency; $0 always reads 0
//   hi_o, lo_o     current HI / LO
//
// Interface: there is no valid/ready handshake. Every cycle's bus content
// is consumed unconditionally; an all-zero bus is a bubble and changes
// nothing. Stalls and bubbles are produced upstream.
//
// Build option: REGFILE_BYPASS_EN enables same-cycle write-through on the
// GPR read ports and on HI/LO. Without it reads return stored values only.
module regfile_hilo
  import regfile_hilo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [DATA_W-1:0]      rdata1,
  output logic [DATA_W-1:0]      rdata2,
  output logic [DATA_W-1:0]      hi_o,
  output logic [DATA_W-1:0]      lo_o
);

  wb_to_rf_t wb;
  assign wb = wb_to_rf_t'(wb_to_rf_bus);

  // A write to $0 is dropped entirely, so entry 0 stays at its reset zero.
  logic gpr_wr;
  assign gpr_wr = wb.rf_we && (wb.rf_waddr != '0);

  logic [DATA_W-1:0] gpr [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= ZERO_WORD;
    end else if (gpr_wr) begin
      gpr[wb.rf_waddr] <= wb.rf_wdata;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? ZERO_WORD : gpr[raddr1];
    rdata2 = (raddr2 == '0) ? ZERO_WORD : gpr[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (gpr_wr && (wb.rf_waddr == raddr1)) rdata1 = wb.rf_wdata;
    if (gpr_wr && (wb.rf_waddr == raddr2)) rdata2 = wb.rf_wdata;
`endif
    if (rst) begin
      rdata1 = ZERO_WORD;
      rdata2 = ZERO_WORD;
    end
  end

  hilo_reg u_hilo_reg (
    .clk   (clk),
    .rst   (rst),
    .hi_we (wb.hi_we),
    .hi_i  (wb.hi_i),
    .lo_we (wb.lo_we),
    .lo_i  (wb.lo_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// tb_regfile_hilo: directed steps followed by random traffic, checked
// against an array-based architectural model of the register file.
module tb_regfile_hilo;

  logic         clk;
  logic         rst;
  logic [103:0] wb_to_rf_bus;
  logic [4:0]   raddr1;
  logic [4:0]   raddr2;
  logic [31:0]  rdata1;
  logic [31:0]  rdata2;
  logic [31:0]  hi_o;
  logic [31:0]  lo_o;

  int n_checks;
  int n_fail;

  // Reference architectural state.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  regfile_hilo dut (
    .clk          (clk),
    .rst          (rst),
    .wb_to_rf_bus (wb_to_rf_bus),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [103:0] mk_bus(input logic hi_we, input logic [31:0] hi,
                                          input logic lo_we, input logic [31:0] lo,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
    return {hi_we, hi, lo_we, lo, we, wa, wd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model of what a read port shows this cycle, given current inputs.
  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    we = wb_to_rf_bus[37];
    wa = wb_to_rf_bus[36:32];
    wd = wb_to_rf_bus[31:0];
    if (rst) return 32'h0;
    if (ra == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra) return wd;
`endif
    return m_gpr[ra];
  endfunction

  function automatic logic [31:0] exp_hi();
    if (rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_to_rf_bus[103]) return wb_to_rf_bus[102:71];
`endif
    return m_hi;
  endfunction

  function automatic logic [31:0] exp_lo();
    if (rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_to_rf_bus[70]) return wb_to_rf_bus[69:38];
`endif
    return m_lo;
  endfunction

  // One cycle: apply inputs, check combinational outputs, clock, update model.
  task automatic step(input string tag, input logic r, input logic [103:0] bus,
                      input logic [4:0] a1, input logic [4:0] a2);
    rst          = r;
    wb_to_rf_bus = bus;
    raddr1       = a1;
    raddr2       = a2;
    #1;
    check({tag, ".rdata1"}, rdata1, exp_rd(a1));
    check({tag, ".rdata2"}, rdata2, exp_rd(a2));
    check({tag, ".hi"}, hi_o, exp_hi());
    check({tag, ".lo"}, lo_o, exp_lo());
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (bus[37] && bus[36:32] != 5'd0) m_gpr[bus[36:32]] = bus[31:0];
      if (bus[103]) m_hi = bus[102:71];
      if (bus[70])  m_lo = bus[69:38];
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [103:0] rb;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    wb_to_rf_bus = '0;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'hx;
    m_hi = 32'hx;
    m_lo = 32'hx;
    @(posedge clk);
    #1;

    // Reset, then read back zeros after release.
    step("rst0", 1'b1, '0, 5'd5, 5'd31);
    step("rst1", 1'b1, '0, 5'd5, 5'd31);
    step("post_rst", 1'b0, '0, 5'd5, 5'd31);
    check("post_rst.const_rdata1", rdata1, 32'h0);
    check("post_rst.const_hi", hi_o, 32'h0);

    // Basic write then read.
    step("wr8", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd8, 32'hDEADBEEF), 5'd8, 5'd0);
    step("rd8a", 1'b0, '0, 5'd8, 5'd8);
    check("rd8.const", rdata1, 32'hDEADBEEF);
    step("rd8b", 1'b0, '0, 5'd8, 5'd1);

    // $0 protection.
    step("wr0", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF), 5'd0, 5'd0);
    step("rd0", 1'b0, '0, 5'd0, 5'd0);
    check("rd0.const", rdata1, 32'h0);

    // HI then LO independently.
    step("wr_hi", 1'b0, mk_bus(1, 32'h12345678, 0, 32'h55555555, 0, 0, 0), 5'd8, 5'd0);
    step("wr_lo", 1'b0, mk_bus(0, 32'hAAAAAAAA, 1, 32'h9ABCDEF0, 0, 0, 0), 5'd8, 5'd0);
    step("rd_hilo", 1'b0, '0, 5'd0, 5'd0);
    check("hilo.const_hi", hi_o, 32'h12345678);
    check("hilo.const_lo", lo_o, 32'h9ABCDEF0);

    // Same-cycle hazard on GPR[3].
    step("pre3", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd3, 32'h11), 5'd0, 5'd0);
    step("haz3", 1'b0, mk_bus(0, 0, 0, 0, 1, 5'd3, 32'h22), 5'd3, 5'd3);
    step("haz3_next", 1'b0, '0, 5'd3, 5'd3);
    check("haz3.const", rdata2, 32'h22);

    // Reset priority over simultaneous writes.
    step("rst_pri", 1'b1, mk_bus(1, 32'hBB, 1, 32'hCC, 1, 5'd4, 32'hAA), 5'd4, 5'd8);
    step("rst_pri_after", 1'b0, '0, 5'd4, 5'd8);
    check("rst_pri.const_gpr4", rdata1, 32'h0);
    check("rst_pri.const_hi", hi_o, 32'h0);

    // Random traffic, with both-ports-equal-waddr collisions made frequent.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, a1, a2;
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      rb = mk_bus(1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), wa, $urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      step("rand", ($urandom_range(0, 39) == 0), rb, a1, a2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
